raster_mixer: RTL and testbench



---
 rtl/pong_pkg.sv | 28 ++
 rtl/video_sync_gen.sv | 51 +++++
 rtl/raster_mixer.sv | 158 +++++++++++++++
 tb/tb_raster_mixer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: types and constants shared by the Pong datapath blocks.
//   FrameState : frame sequencing states used by raster_mixer.
//   PIX_*      : 2-bit pixel encoding fed to the video DAC.
//   DEF_*      : default video timing and game constants, shared with the
//                ball and paddle blocks so every block agrees on the raster.
package pong_pkg;

  typedef enum logic [1:0] {
    Draw  = 2'd0,
    Blank = 2'd1,
    Tally = 2'd2
  } FrameState;

  localparam logic [1:0] PIX_BLACK = 2'd0;
  localparam logic [1:0] PIX_SHADE = 2'd1;
  localparam logic [1:0] PIX_OBJ   = 2'd3;

  localparam int DEF_WIDTH_VIDEO    = 10;
  localparam int DEF_H_TOTAL        = 800;
  localparam int DEF_H_VIS          = 640;
  localparam int DEF_V_TOTAL        = 525;
  localparam int DEF_V_VIS          = 480;
  localparam int DEF_WALL_H         = 8;
  localparam int DEF_GOAL_W         = 4;
  localparam int DEF_WIN_SCORE      = 9;
  localparam int DEF_HOLDOFF_FRAMES = 60;

endpackage

// File: rtl/video_sync_gen.sv
// video_sync_gen: one-pixel-per-clock raster counters and sync pulses.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   hcount       : current column, wraps at H_TOTAL-1
//   vcount       : current line, advances on each hcount wrap
//   hsync        : one-cycle pulse on the last column of every line
//   vsync        : one-cycle pulse on the last column of the last line
//   vis          : current pixel lies in the visible area
module video_sync_gen
  import pong_pkg::*;
#(
  parameter int WIDTH_VIDEO = DEF_WIDTH_VIDEO,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_VIS       = DEF_H_VIS,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_VIS       = DEF_V_VIS
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [WIDTH_VIDEO-1:0] hcount,
  output logic [WIDTH_VIDEO-1:0] vcount,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   vis
);

  localparam logic [WIDTH_VIDEO-1:0] ONE    = WIDTH_VIDEO'(1);
  localparam logic [WIDTH_VIDEO-1:0] H_LAST = WIDTH_VIDEO'(H_TOTAL - 1);
  localparam logic [WIDTH_VIDEO-1:0] V_LAST = WIDTH_VIDEO'(V_TOTAL - 1);
  localparam logic [WIDTH_VIDEO-1:0] H_VISC = WIDTH_VIDEO'(H_VIS);
  localparam logic [WIDTH_VIDEO-1:0] V_VISC = WIDTH_VIDEO'(V_VIS);

  always_ff @(posedge clock) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + ONE;
    end else begin
      hcount <= hcount + ONE;
    end
  end

  // Pulses are suppressed during reset so a reset landing on the last
  // column cannot leak a stray sync to the ball FSM.
  assign hsync = !reset && (hcount == H_LAST);
  assign vsync = hsync && (vcount == V_LAST);
  assign vis   = (hcount < H_VISC) && (vcount < V_VISC);

endmodule

// File: rtl/raster_mixer.sv
// raster_mixer: video timing, pixel compositing, ball collision feedback
// and goal/score keeping for Pong.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   BitRaster        : ball interior bit for the current pixel
//   BitRasterShade   : ball shadow bit for the current pixel
//   PaddleRaster     : OR of both paddle raster bits
//   HSync, VSync     : one-cycle line / frame start pulses
//   RasterCollision  : ball overlaps wall or paddle (combinational)
//   Pixel, Visible   : registered 2-bit pixel and visible flag
//   ScoreL, ScoreR   : player scores, saturating at WIN_SCORE
//   GameOver         : sticky once a score reaches WIN_SCORE
// Build option: define SHADE_EN to let BitRasterShade produce PIX_SHADE;
// without it the shadow input is ignored and Pixel is only 0 or 3.
//
// state | meaning
// Draw  | visible lines being scanned, goal flags collecting
// Blank | vertical blanking, waiting for VSync
// Tally | one cycle: score the finished frame, clear goal flags
module raster_mixer
  import pong_pkg::*;
#(
  parameter int WIDTH_VIDEO    = DEF_WIDTH_VIDEO,
  parameter int H_TOTAL        = DEF_H_TOTAL,
  parameter int H_VIS          = DEF_H_VIS,
  parameter int V_TOTAL        = DEF_V_TOTAL,
  parameter int V_VIS          = DEF_V_VIS,
  parameter int WALL_H         = DEF_WALL_H,
  parameter int GOAL_W         = DEF_GOAL_W,
  parameter int WIN_SCORE      = DEF_WIN_SCORE,
  parameter int HOLDOFF_FRAMES = DEF_HOLDOFF_FRAMES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       BitRaster,
  input  logic       BitRasterShade,
  input  logic       PaddleRaster,
  output logic       HSync,
  output logic       VSync,
  output logic       RasterCollision,
  output logic [1:0] Pixel,
  output logic       Visible,
  output logic [3:0] ScoreL,
  output logic [3:0] ScoreR,
  output logic       GameOver
);

  localparam int HW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  localparam logic [WIDTH_VIDEO-1:0] WALL_TOP   = WIDTH_VIDEO'(WALL_H);
  localparam logic [WIDTH_VIDEO-1:0] WALL_BOT   = WIDTH_VIDEO'(V_VIS - WALL_H);
  localparam logic [WIDTH_VIDEO-1:0] V_VISC     = WIDTH_VIDEO'(V_VIS);
  localparam logic [WIDTH_VIDEO-1:0] GOAL_L_END = WIDTH_VIDEO'(GOAL_W);
  localparam logic [WIDTH_VIDEO-1:0] GOAL_R_BEG = WIDTH_VIDEO'(H_VIS - GOAL_W);
  localparam logic [3:0]             WIN_C      = 4'(WIN_SCORE);
  localparam logic [3:0]             SCORE_ONE  = 4'd1;
  localparam logic [HW-1:0]          HOLD_C     = HW'(HOLDOFF_FRAMES);
  localparam logic [HW-1:0]          HOLD_ONE   = HW'(1);

  logic [WIDTH_VIDEO-1:0] hcount;
  logic [WIDTH_VIDEO-1:0] vcount;
  logic                   vis;
  logic                   wall;
  logic                   hit;
  logic                   hit_l;
  logic                   hit_r;
  logic                   shade;
  logic [1:0]             pix_next;
  logic                   goal_l;
  logic                   goal_r;
  logic [HW-1:0]          holdoff;
  FrameState              state;

  video_sync_gen #(
    .WIDTH_VIDEO (WIDTH_VIDEO),
    .H_TOTAL     (H_TOTAL),
    .H_VIS       (H_VIS),
    .V_TOTAL     (V_TOTAL),
    .V_VIS       (V_VIS)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .hcount (hcount),
    .vcount (vcount),
    .hsync  (HSync),
    .vsync  (VSync),
    .vis    (vis)
  );

  assign wall  = vis && ((vcount < WALL_TOP) || (vcount >= WALL_BOT));
  assign hit   = vis && BitRaster;
  assign hit_l = hit && (hcount < GOAL_L_END);
  assign hit_r = hit && (hcount >= GOAL_R_BEG);

  // Gated by reset so every output reads 0 during the reset cycle.
  assign RasterCollision = !reset && hit && (wall || PaddleRaster);

`ifdef SHADE_EN
  assign shade = vis && BitRasterShade;
`else
  logic unused_shade;
  assign unused_shade = BitRasterShade;
  assign shade        = 1'b0;
`endif

  always_comb begin
    pix_next = PIX_BLACK;
    if (vis && (BitRaster || PaddleRaster || wall)) pix_next = PIX_OBJ;
    else if (shade)                                 pix_next = PIX_SHADE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= Draw;
    end else begin
      case (state)
        Draw:    if (vcount >= V_VISC) state <= Blank;
        Blank:   if (VSync) state <= Tally;
        Tally:   state <= Draw;
        default: state <= Draw;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Pixel    <= PIX_BLACK;
      Visible  <= 1'b0;
      goal_l   <= 1'b0;
      goal_r   <= 1'b0;
      holdoff  <= '0;
      ScoreL   <= '0;
      ScoreR   <= '0;
      GameOver <= 1'b0;
    end else begin
      Pixel   <= pix_next;
      Visible <= vis;
      // Tally lands on pixel (0,0) of the next frame; a hit there belongs to
      // the new frame, so it survives the clear.
      goal_l  <= ((state == Tally) ? 1'b0 : goal_l) | hit_l;
      goal_r  <= ((state == Tally) ? 1'b0 : goal_r) | hit_r;
      if ((state == Tally) && !GameOver) begin
        if (holdoff != '0) begin
          holdoff <= holdoff - HOLD_ONE;
        end else if (goal_l && !goal_r) begin
          ScoreR  <= ScoreR + SCORE_ONE;
          holdoff <= HOLD_C;
          if (ScoreR + SCORE_ONE == WIN_C) GameOver <= 1'b1;
        end else if (goal_r && !goal_l) begin
          ScoreL  <= ScoreL + SCORE_ONE;
          holdoff <= HOLD_C;
          if (ScoreL + SCORE_ONE == WIN_C) GameOver <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_raster_mixer.sv
// Testbench for raster_mixer with a small raster (16x10, 12x8 visible).
// A frame-level model checks every output on every cycle; directed
// scenarios add hand-computed literal expectations.
module tb_raster_mixer;

  localparam int HT   = 16;
  localparam int HV   = 12;
  localparam int VT   = 10;
  localparam int VV   = 8;
  localparam int WH   = 1;
  localparam int GW   = 2;
  localparam int WIN  = 2;
  localparam int HOLD = 1;
  localparam int FRAME = HT * VT;
`ifdef SHADE_EN
  localparam int EXP_SHADE = 1;
`else
  localparam int EXP_SHADE = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       br = 1'b0;
  logic       bs = 1'b0;
  logic       pr = 1'b0;
  logic       hsync, vsync, coll, visible, game_over;
  logic [1:0] pixel;
  logic [3:0] score_l, score_r;

  raster_mixer #(
    .WIDTH_VIDEO    (10),
    .H_TOTAL        (HT),
    .H_VIS          (HV),
    .V_TOTAL        (VT),
    .V_VIS          (VV),
    .WALL_H         (WH),
    .GOAL_W         (GW),
    .WIN_SCORE      (WIN),
    .HOLDOFF_FRAMES (HOLD)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .BitRaster       (br),
    .BitRasterShade  (bs),
    .PaddleRaster    (pr),
    .HSync           (hsync),
    .VSync           (vsync),
    .RasterCollision (coll),
    .Pixel           (pixel),
    .Visible         (visible),
    .ScoreL          (score_l),
    .ScoreR          (score_r),
    .GameOver        (game_over)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model state: position of the current cycle and expected registered outputs.
  bit m_valid = 0;
  int m_t = 0, m_h = 0, m_v = 0;
  int e_pix = 0, e_vis = 0, e_sl = 0, e_sr = 0, e_over = 0;
  bit m_gl = 0, m_gr = 0;
  int m_hold = 0;
  int first_hs = -1, first_vs = -1, vs_cnt = 0;

  always @(negedge clock) begin
    if (reset) begin
      check("hsync_in_reset", hsync, 0);
      check("vsync_in_reset", vsync, 0);
      check("coll_in_reset", coll, 0);
      m_valid = 1;
      m_t = 0; m_h = 0; m_v = 0;
      e_pix = 0; e_vis = 0; e_sl = 0; e_sr = 0; e_over = 0;
      m_gl = 0; m_gr = 0; m_hold = 0;
      first_hs = -1; first_vs = -1; vs_cnt = 0;
    end else if (m_valid) begin
      automatic int  h    = m_t % HT;
      automatic int  v    = (m_t / HT) % VT;
      automatic bit  vis  = (h < HV) && (v < VV);
      automatic bit  wall = vis && ((v < WH) || (v >= VV - WH));
      automatic bit  ehs  = (h == HT - 1);
      automatic bit  evs  = ehs && (v == VT - 1);
      check("hsync", hsync, int'(ehs));
      check("vsync", vsync, int'(evs));
      check("collision", coll, int'(vis && br && (wall || pr)));
      check("pixel", pixel, e_pix);
      check("visible", visible, e_vis);
      check("score_l", score_l, e_sl);
      check("score_r", score_r, e_sr);
      check("game_over", game_over, e_over);
      if (hsync && first_hs < 0) first_hs = m_t;
      if (vsync && first_vs < 0) first_vs = m_t;
      if (vsync) vs_cnt++;
      // Registered outputs for the next cycle.
      if (vis && (br || pr || wall)) e_pix = 3;
      else if (EXP_SHADE == 1 && vis && bs) e_pix = 1;
      else e_pix = 0;
      e_vis = int'(vis);
      // Scoring happens on the first cycle of each new frame.
      if (m_t > 0 && (m_t % FRAME) == 0) begin
        if (e_over == 0) begin
          if (m_hold > 0) m_hold--;
          else if (m_gl && !m_gr) begin
            e_sr++; m_hold = HOLD;
            if (e_sr == WIN) e_over = 1;
          end else if (m_gr && !m_gl) begin
            e_sl++; m_hold = HOLD;
            if (e_sl == WIN) e_over = 1;
          end
        end
        m_gl = 0; m_gr = 0;
      end
      if (vis && br && h < GW) m_gl = 1;
      if (vis && br && h >= HV - GW) m_gr = 1;
      m_t++;
      m_h = m_t % HT;
      m_v = (m_t / HT) % VT;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    br = 0; bs = 0; pr = 0;
    repeat (n) step();
  endtask

  task automatic goto(input int v, input int h);
    int budget;
    budget = 2 * FRAME;
    br = 0; bs = 0; pr = 0;
    while (!(m_v == v && m_h == h)) begin
      if (budget == 0) begin
        check("goto_timeout", 0, 1);
        return;
      end
      step();
      budget--;
    end
  endtask

  task automatic goal_at(input int v, input int h);
    goto(v, h);
    br = 1;
    step();
    br = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // Free-run timing.
    idle(2 * FRAME);
    check("first_hsync_cycle", first_hs, 15);
    check("first_vsync_cycle", first_vs, 159);
    check("vsync_count_2_frames", vs_cnt, 2);

    // Ball on top wall.
    goto(0, 5);
    br = 1;
    @(negedge clock);
    check("coll_top_wall", coll, 1);
    step();
    br = 0;
    @(negedge clock);
    check("pixel_top_wall", pixel, 3);

    // Ball mid-field, without then with paddle.
    goto(3, 5);
    br = 1; pr = 0;
    @(negedge clock);
    check("coll_no_paddle", coll, 0);
    step();
    br = 1; pr = 1;
    @(negedge clock);
    check("coll_paddle", coll, 1);
    step();
    br = 0; pr = 0;

    // Shadow pixel alone.
    goto(4, 5);
    bs = 1;
    step();
    bs = 0;
    check("pixel_shade", pixel, EXP_SHADE);

    // Left goals over consecutive frames.
    goal_at(3, 0);
    goto(0, 5);
    check("score_r_after_goal1", score_r, 1);
    goal_at(3, 0);
    goto(0, 5);
    check("score_r_holdoff", score_r, 1);
    goal_at(3, 0);
    goto(0, 5);
    check("score_r_win", score_r, 2);
    check("game_over_set", game_over, 1);
    goal_at(3, 11);
    goto(0, 5);
    check("score_l_frozen", score_l, 0);
    check("score_r_frozen", score_r, 2);

    // Fresh game: both goal zones hit in one frame.
    reset = 1;
    step();
    reset = 0;
    check("score_r_after_reset", score_r, 0);
    check("game_over_after_reset", game_over, 0);
    goal_at(3, 0);
    goal_at(3, 11);
    goto(0, 5);
    check("both_goals_l", score_l, 0);
    check("both_goals_r", score_r, 0);
    goal_at(3, 11);
    goto(0, 5);
    check("right_goal_scores_l", score_l, 1);

    // Mid-frame reset.
    goto(4, 7);
    reset = 1;
    step();
    reset = 0;
    check("mid_reset_pixel", pixel, 0);
    check("mid_reset_visible", visible, 0);
    check("mid_reset_score_l", score_l, 0);
    idle(20);
    check("mid_reset_first_hsync", first_hs, 15);

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
